// File: rtl/yuv2rgb_pkg.sv
// Shared constants, tag struct and arithmetic helpers for the YCbCr 4:2:2 -> RGB receive path.
// Optional build macro used by the top: YUV2RGB_FRM_CNT_EN (per-frame pixel counter).
package yuv2rgb_pkg;

  localparam int P_LAT = 6;
  localparam int P_CW  = 9;
  localparam int P_DW  = 8;
  localparam int P_SW  = 19;

  localparam logic [P_CW-1:0]        K_R_CR   = 9'd359;
  localparam logic [P_CW-1:0]        K_G_CB   = 9'd88;
  localparam logic [P_CW-1:0]        K_G_CR   = 9'd183;
  localparam logic [P_CW-1:0]        K_B_CB   = 9'd454;
  localparam logic [P_DW-1:0]        C_OFFSET = 8'd128;
  localparam logic signed [P_SW-1:0] ROUND    = 19'sd128;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } tag_t;

  // Unsigned Q8 coefficient times signed chroma difference, full 19b signed product.
  function automatic logic signed [P_SW-1:0] cmul(input logic [P_CW-1:0] k,
                                                  input logic signed [8:0] d);
    logic signed [P_SW-1:0] ks;
    logic signed [P_SW-1:0] ds;
    ks = $signed({{(P_SW-P_CW){1'b0}}, k});
    ds = {{(P_SW-9){d[8]}}, d};
    return ks * ds;
  endfunction

  function automatic logic signed [8:0] cdiff(input logic [P_DW-1:0] c);
    return $signed({1'b0, c}) - $signed({1'b0, C_OFFSET});
  endfunction

  function automatic logic [P_DW-1:0] clamp8(input logic signed [10:0] v);
    if (v < 11'sd0)        return 8'd0;
    else if (v > 11'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

endpackage

// File: rtl/yuv2rgb_csc.sv
// Colour-space back end: multiply, sum+round, clamp. Three register stages, tags ride alongside.
module yuv2rgb_csc
  import yuv2rgb_pkg::*;
(
  input  logic            i_sclk,
  input  logic            i_rst,
  input  logic [P_DW-1:0] i_y,
  input  logic [P_DW-1:0] i_cb,
  input  logic [P_DW-1:0] i_cr,
  input  tag_t            i_tag,
  output logic [P_DW-1:0] o_r,
  output logic [P_DW-1:0] o_g,
  output logic [P_DW-1:0] o_b,
  output tag_t            o_tag
);

  logic signed [8:0]      w_cbd, w_crd;
  logic signed [P_SW-1:0] r3_yq, r3_rcr, r3_gcb, r3_gcr, r3_bcb;
  tag_t                   r3_tag, r4_tag;
  logic signed [P_SW-1:0] w_r_sum, w_g_sum, w_b_sum;
  logic signed [10:0]     r4_r, r4_g, r4_b;

  assign w_cbd = cdiff(i_cb);
  assign w_crd = cdiff(i_cr);

  // Arithmetic >>>8 is a plain slice of the upper 11 bits (floor toward -inf).
  assign w_r_sum = r3_yq + r3_rcr + ROUND;
  assign w_g_sum = r3_yq - r3_gcb - r3_gcr + ROUND;
  assign w_b_sum = r3_yq + r3_bcb + ROUND;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r3_yq  <= '0;
      r3_rcr <= '0;
      r3_gcb <= '0;
      r3_gcr <= '0;
      r3_bcb <= '0;
      r3_tag <= '0;
      r4_r   <= '0;
      r4_g   <= '0;
      r4_b   <= '0;
      r4_tag <= '0;
      o_r    <= '0;
      o_g    <= '0;
      o_b    <= '0;
      o_tag  <= '0;
    end else begin
      r3_yq  <= $signed({3'b000, i_y, 8'h00});
      r3_rcr <= cmul(K_R_CR, w_crd);
      r3_gcb <= cmul(K_G_CB, w_cbd);
      r3_gcr <= cmul(K_G_CR, w_crd);
      r3_bcb <= cmul(K_B_CB, w_cbd);
      r3_tag <= i_tag;
      r4_r   <= w_r_sum[P_SW-1:8];
      r4_g   <= w_g_sum[P_SW-1:8];
      r4_b   <= w_b_sum[P_SW-1:8];
      r4_tag <= r3_tag;
      o_r    <= clamp8(r4_r);
      o_g    <= clamp8(r4_g);
      o_b    <= clamp8(r4_b);
      o_tag  <= r4_tag;
    end
  end

endmodule

// File: rtl/yuv422_to_rgb.sv
// 4:2:2 {Y,C} stream -> 8-bit RGB, fixed 6-clock latency. Front end tracks pixel phase and pairs chroma.
// Define YUV2RGB_FRM_CNT_EN to add the per-frame de pixel counter and o_frm_pixel_cnt port.
module yuv422_to_rgb
  import yuv2rgb_pkg::*;
(
  input  logic            i_sclk,
  input  logic            i_rst,
  input  logic [15:0]     i_data,
  input  logic            i_vsync,
  input  logic            i_hsync,
  input  logic            i_de,
  output logic [P_DW-1:0] o_R,
  output logic [P_DW-1:0] o_G,
  output logic [P_DW-1:0] o_B,
  output logic            o_vsync,
  output logic            o_hsync,
  output logic            o_de
`ifdef YUV2RGB_FRM_CNT_EN
  ,
  output logic [23:0]     o_frm_pixel_cnt
`endif
);

  logic [P_DW-1:0] r0_y, r0_c, r1_y, r1_c, r2_y, r2_c, r3_c;
  tag_t            r0_tag, r1_tag, r2_tag, w_out_tag;
  logic            r_phase, r1_ph, r2_ph, r3_ph, r3_de;
  logic            w_adv, w_s1_odd, w_s3_even;
  logic [P_DW-1:0] w_cb, w_cr;

  // Phase restarts at 0 on every blank or vsync cycle, so each line opens with Cb.
  assign w_adv = r0_tag.de & ~r0_tag.vs;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r0_y    <= '0;
      r0_c    <= '0;
      r0_tag  <= '0;
      r1_y    <= '0;
      r1_c    <= '0;
      r1_tag  <= '0;
      r1_ph   <= 1'b0;
      r_phase <= 1'b0;
      r2_y    <= '0;
      r2_c    <= '0;
      r2_tag  <= '0;
      r2_ph   <= 1'b0;
      r3_c    <= '0;
      r3_ph   <= 1'b0;
      r3_de   <= 1'b0;
    end else begin
      r0_y    <= i_data[15:8];
      r0_c    <= i_data[7:0];
      r0_tag  <= '{vs: i_vsync, hs: i_hsync, de: i_de};
      r1_y    <= r0_y;
      r1_c    <= r0_c;
      r1_tag  <= r0_tag;
      r1_ph   <= w_adv ? r_phase : 1'b0;
      r_phase <= w_adv ? ~r_phase : 1'b0;
      r2_y    <= r1_y;
      r2_c    <= r1_c;
      r2_tag  <= r1_tag;
      r2_ph   <= r1_ph;
      r3_c    <= r2_c;
      r3_ph   <= r2_ph;
      r3_de   <= r2_tag.de;
    end
  end

  // Even pixel borrows Cr from its successor (S1); odd pixel borrows Cb from its predecessor (S3).
  assign w_s1_odd  = r1_tag.de & r1_ph;
  assign w_s3_even = r3_de & ~r3_ph;
  assign w_cb      = r2_ph ? (w_s3_even ? r3_c : C_OFFSET) : r2_c;
  assign w_cr      = r2_ph ? r2_c : (w_s1_odd ? r1_c : C_OFFSET);

  yuv2rgb_csc u_csc (
    .i_sclk (i_sclk),
    .i_rst  (i_rst),
    .i_y    (r2_y),
    .i_cb   (w_cb),
    .i_cr   (w_cr),
    .i_tag  (r2_tag),
    .o_r    (o_R),
    .o_g    (o_G),
    .o_b    (o_B),
    .o_tag  (w_out_tag)
  );

  assign o_vsync = w_out_tag.vs;
  assign o_hsync = w_out_tag.hs;
  assign o_de    = w_out_tag.de;

`ifdef YUV2RGB_FRM_CNT_EN
  logic [23:0] r_cnt;
  logic        r_vs_d;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_cnt           <= '0;
      r_vs_d          <= 1'b0;
      o_frm_pixel_cnt <= '0;
    end else begin
      r_vs_d <= i_vsync;
      if (i_vsync)
        r_cnt <= '0;
      else if (i_de && r_cnt != 24'hFF_FFFF)
        r_cnt <= r_cnt + 24'd1;
      if (i_vsync && !r_vs_d)
        o_frm_pixel_cnt <= r_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Directed bench for yuv422_to_rgb: hand-computed RGB/tag expectations checked P_LAT cycles after drive.
module tb_yuv422_to_rgb;
  import yuv2rgb_pkg::*;

  logic        i_sclk = 1'b0;
  logic        i_rst  = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0;
  logic [7:0]  o_R, o_G, o_B;
  logic        o_vsync, o_hsync, o_de;
`ifdef YUV2RGB_FRM_CNT_EN
  logic [23:0] o_frm_pixel_cnt;
`endif

  always #5 i_sclk = ~i_sclk;

  yuv422_to_rgb dut (
    .i_sclk  (i_sclk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_vsync (i_vsync),
    .i_hsync (i_hsync),
    .i_de    (i_de),
    .o_R     (o_R),
    .o_G     (o_G),
    .o_B     (o_B),
    .o_vsync (o_vsync),
    .o_hsync (o_hsync),
    .o_de    (o_de)
`ifdef YUV2RGB_FRM_CNT_EN
    ,
    .o_frm_pixel_cnt (o_frm_pixel_cnt)
`endif
  );

  typedef struct {
    bit         v;
    bit         c;
    logic [7:0] r, g, b;
    logic       vs, hs, de;
  } exp_t;

  exp_t ex [0:511];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Outputs visible now belong to the cycle driven P_LAT steps ago.
  task automatic cmp_out();
    int j;
    j = cyc - P_LAT;
    if (j >= 0 && ex[j].v) begin
      chk($sformatf("vsync@%0d", j), {23'd0, o_vsync}, {23'd0, ex[j].vs});
      chk($sformatf("hsync@%0d", j), {23'd0, o_hsync}, {23'd0, ex[j].hs});
      chk($sformatf("de@%0d", j),    {23'd0, o_de},    {23'd0, ex[j].de});
      if (ex[j].c) begin
        chk($sformatf("R@%0d", j), {16'd0, o_R}, {16'd0, ex[j].r});
        chk($sformatf("G@%0d", j), {16'd0, o_G}, {16'd0, ex[j].g});
        chk($sformatf("B@%0d", j), {16'd0, o_B}, {16'd0, ex[j].b});
      end
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] y, input logic [7:0] c,
                      input logic vs, input logic hs, input logic de,
                      input bit chk_rgb, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    cmp_out();
    i_rst   = rst;
    i_data  = {y, c};
    i_vsync = vs;
    i_hsync = hs;
    i_de    = de;
    ex[cyc] = '{v: 1'b1, c: chk_rgb, r: r, g: g, b: b, vs: vs, hs: hs, de: de};
    cyc++;
    @(posedge i_sclk);
    #1;
  endtask

  task automatic pix(input logic [7:0] y, input logic [7:0] c,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    step(1'b0, y, c, 1'b0, 1'b0, 1'b1, 1'b1, r, g, b);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic tagv(input logic vs, input logic hs, input logic de);
    step(1'b0, 8'h55, 8'h80, vs, hs, de, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    int k;

    // reset state
    repeat (2) @(posedge i_sclk);
    #1;
    chk("rst_R", {16'd0, o_R}, 24'd0);
    chk("rst_G", {16'd0, o_G}, 24'd0);
    chk("rst_B", {16'd0, o_B}, 24'd0);
    chk("rst_vs", {23'd0, o_vsync}, 24'd0);
    chk("rst_hs", {23'd0, o_hsync}, 24'd0);
    chk("rst_de", {23'd0, o_de}, 24'd0);

    // mid-grey line
    idle();
    for (int i = 0; i < 8; i++) pix(8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    idle();

    // basic pair
    pix(8'd100, 8'd90,  8'd145, 8'd90,  8'd33);
    pix(8'd200, 8'd160, 8'd245, 8'd190, 8'd133);
    idle();

    // negative and positive clamp pairs
    pix(8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    pix(8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    pix(8'd255, 8'd128, 8'd255, 8'd164, 8'd255);
    pix(8'd255, 8'd255, 8'd255, 8'd164, 8'd255);
    idle();

    // odd-length line, then next line must start on Cb
    pix(8'd100, 8'd90,  8'd145, 8'd90,  8'd33);
    pix(8'd200, 8'd160, 8'd245, 8'd190, 8'd133);
    pix(8'd50,  8'd200, 8'd50,  8'd25,  8'd178);
    idle();
    pix(8'd100, 8'd90,  8'd145, 8'd90,  8'd33);
    pix(8'd200, 8'd160, 8'd245, 8'd190, 8'd133);
    idle();

    // tag alignment pattern
    tagv(1'b1, 1'b0, 1'b0);
    tagv(1'b1, 1'b1, 1'b0);
    tagv(1'b0, 1'b1, 1'b0);
    tagv(1'b0, 1'b0, 1'b1);
    tagv(1'b0, 1'b0, 1'b1);
    tagv(1'b0, 1'b1, 1'b0);
    tagv(1'b0, 1'b0, 1'b0);
    tagv(1'b1, 1'b0, 1'b1);
    tagv(1'b0, 1'b0, 1'b1);
    tagv(1'b0, 1'b1, 1'b1);
    pix(8'd100, 8'd90,  8'd145, 8'd90,  8'd33);
    pix(8'd200, 8'd160, 8'd245, 8'd190, 8'd133);
    idle();

    // reset for one clock mid-line; in-flight pixels are discarded
    step(1'b0, 8'd100, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b1, 8'd200, 8'd160, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    k = cyc - 1;
    for (int i = 0; i < P_LAT; i++)
      ex[k-i] = '{v: 1'b1, c: (i == P_LAT-1), r: 8'd0, g: 8'd0, b: 8'd0, vs: 1'b0, hs: 1'b0, de: 1'b0};
    pix(8'd100, 8'd90,  8'd145, 8'd90,  8'd33);
    pix(8'd200, 8'd160, 8'd245, 8'd190, 8'd133);
    repeat (P_LAT + 1) idle();

`ifdef YUV2RGB_FRM_CNT_EN
    tagv(1'b1, 1'b0, 1'b0);
    tagv(1'b0, 1'b0, 1'b0);
    for (int ln = 0; ln < 4; ln++) begin
      for (int p = 0; p < 10; p++) tagv(1'b0, 1'b0, 1'b1);
      tagv(1'b0, 1'b1, 1'b0);
      tagv(1'b0, 1'b0, 1'b0);
    end
    tagv(1'b1, 1'b0, 1'b0);
    chk("frm_pixel_cnt", o_frm_pixel_cnt, 24'd40);
    repeat (P_LAT + 1) idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
